// File: rtl/ifft_butterfly16_stream.sv
// ---------------------------------------------------------------------------
// ifft_butterfly16_stream
//
// Streaming inverse radix-2 butterfly stage for the 16-point transform path.
// It collects one 16-sample complex frame, runs eight butterflies (one per
// cycle) and then streams the 16 results out under ready/valid flow control.
//
//   y_k     = (x_k + x_{k+8}) >>> 8                      k = 0..7
//   y_{k+8} = ((x_k - x_{k+8}) * C_k) >>> 15             C_k = conjugate Q7 twiddle
//
// The 8-bit shift removes the forward stage's x128 gain plus the 1/2 of the
// inverse butterfly. The 15-bit shift removes that same gain and 1/2, and
// also the Q7 scale of C_k.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   input sample valid
//   in_ready   out  1   block can accept a sample (FILL only)
//   in_Real    in   64  signed real part of input sample
//   in_Im      in   64  signed imaginary part of input sample
//   out_valid  out  1   output sample valid (DRAIN only)
//   out_ready  in   1   downstream accepts output
//   out_Real   out  64  signed real result (0 outside DRAIN)
//   out_Im     out  64  signed imaginary result (0 outside DRAIN)
//   out_last   out  1   high with the 16th output sample of a frame
//
// Build option
//   IFFT_ROUND_EN  when defined, add 2^(s-1) before each arithmetic shift by s
//                  (round half up). When undefined, the shift is a plain floor.
//                  Latency and handshakes are the same in both builds.
// ---------------------------------------------------------------------------
module ifft_butterfly16_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_Real,
    input  logic [63:0] in_Im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_Real,
    output logic [63:0] out_Im,
    output logic        out_last
);

    // Internal arithmetic width. It is wide enough for a 66-bit difference
    // times a 32-bit twiddle, plus the cross-term sum and the rounding offset.
    localparam int WIDE = 100;

`ifdef IFFT_ROUND_EN
    localparam logic signed [WIDE-1:0] RND8  = 100'sd128;
    localparam logic signed [WIDE-1:0] RND15 = 100'sd16384;
`else
    localparam logic signed [WIDE-1:0] RND8  = 100'sd0;
    localparam logic signed [WIDE-1:0] RND15 = 100'sd0;
`endif

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;

    logic [63:0] in_re_q  [16];
    logic [63:0] in_im_q  [16];
    logic [63:0] obuf_re_q[16];
    logic [63:0] obuf_im_q[16];

    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [63:0] out_re_q, out_re_d;
    logic [63:0] out_im_q, out_im_d;

    logic        in_fire_s;
    logic        out_fire_s;

    logic signed [WIDE-1:0] a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [WIDE-1:0] cr_s, ci_s;
    logic signed [WIDE-1:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic signed [WIDE-1:0] prod_re_s, prod_im_s;
    logic signed [WIDE-1:0] top_re_s, top_im_s, bot_re_s, bot_im_s;

    // Sign-extend a 64-bit sample to the internal width.
    function automatic logic signed [WIDE-1:0] sx64(input logic [63:0] v);
        return {{(WIDE-64){v[63]}}, v};
    endfunction

    // Real part of the conjugate twiddle C_k (Q7, 1.0 = 128).
    function automatic logic signed [31:0] tw_re(input logic [2:0] k);
        logic signed [31:0] r;
        case (k)
            3'd0:    r = 32'sd128;
            3'd1:    r = 32'sd118;
            3'd2:    r = 32'sd90;
            3'd3:    r = 32'sd49;
            3'd4:    r = 32'sd0;
            3'd5:    r = -32'sd49;
            3'd6:    r = -32'sd90;
            3'd7:    r = -32'sd118;
            default: r = 32'sd0;
        endcase
        return r;
    endfunction

    // Imaginary part of the conjugate twiddle C_k (Q7).
    function automatic logic signed [31:0] tw_im(input logic [2:0] k);
        logic signed [31:0] r;
        case (k)
            3'd0:    r = 32'sd0;
            3'd1:    r = 32'sd49;
            3'd2:    r = 32'sd90;
            3'd3:    r = 32'sd118;
            3'd4:    r = 32'sd128;
            3'd5:    r = 32'sd118;
            3'd6:    r = 32'sd90;
            3'd7:    r = 32'sd49;
            default: r = 32'sd0;
        endcase
        return r;
    endfunction

    assign in_fire_s  = in_valid && in_ready_q;
    assign out_fire_s = out_valid_q && out_ready;

    // Butterfly datapath for pair (k, k+8). It only uses registered frame data.
    always_comb begin
        a_re_s    = sx64(in_re_q[{1'b0, k_q}]);
        a_im_s    = sx64(in_im_q[{1'b0, k_q}]);
        b_re_s    = sx64(in_re_q[{1'b1, k_q}]);
        b_im_s    = sx64(in_im_q[{1'b1, k_q}]);
        cr_s      = {{(WIDE-32){tw_re(k_q)}}, tw_re(k_q)} ;
        ci_s      = {{(WIDE-32){tw_im(k_q)}}, tw_im(k_q)} ;
        cr_s      = {{(WIDE-32){cr_s[31]}}, cr_s[31:0]};
        ci_s      = {{(WIDE-32){ci_s[31]}}, ci_s[31:0]};
        sum_re_s  = a_re_s + b_re_s;
        sum_im_s  = a_im_s + b_im_s;
        dif_re_s  = a_re_s - b_re_s;
        dif_im_s  = a_im_s - b_im_s;
        prod_re_s = (dif_re_s * cr_s) - (dif_im_s * ci_s);
        prod_im_s = (dif_re_s * ci_s) + (dif_im_s * cr_s);
        top_re_s  = (sum_re_s + RND8) >>> 8;
        top_im_s  = (sum_im_s + RND8) >>> 8;
        bot_re_s  = (prod_re_s + RND15) >>> 15;
        bot_im_s  = (prod_im_s + RND15) >>> 15;
    end

    // Next-state and counter logic for FILL -> COMPUTE -> DRAIN.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        k_d      = k_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            ST_FILL: begin
                if (in_fire_s) begin
                    if (wr_cnt_q == 4'd15) begin
                        state_d  = ST_COMPUTE;
                        wr_cnt_d = 4'd0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 4'd1;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            ST_COMPUTE: begin
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s) begin
                    if (rd_cnt_q == 4'd15) begin
                        state_d  = ST_FILL;
                        rd_cnt_d = 4'd0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 4'd1;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d  = ST_FILL;
                wr_cnt_d = 4'd0;
                k_d      = 3'd0;
                rd_cnt_d = 4'd0;
            end
        endcase
    end

    // Output decode from the next state. All outputs are then registered.
    // While stalled, rd_cnt_d is unchanged, so data and last hold steady.
    always_comb begin
        in_ready_d  = (state_d == ST_FILL);
        out_valid_d = (state_d == ST_DRAIN);
        if (state_d == ST_DRAIN) begin
            out_re_d   = obuf_re_q[rd_cnt_d];
            out_im_d   = obuf_im_q[rd_cnt_d];
            out_last_d = (rd_cnt_d == 4'd15);
        end else begin
            out_re_d   = 64'd0;
            out_im_d   = 64'd0;
            out_last_d = 1'b0;
        end
    end

    // State and counter registers. Reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            wr_cnt_q <= 4'd0;
            k_q      <= 3'd0;
            rd_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            k_q      <= k_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Registered interface outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= 64'd0;
            out_im_q    <= 64'd0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // Frame and result storage. The state machine guards its contents, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            in_re_q[wr_cnt_q] <= in_Real;
            in_im_q[wr_cnt_q] <= in_Im;
        end
        if (state_q == ST_COMPUTE) begin
            obuf_re_q[{1'b0, k_q}] <= top_re_s[63:0];
            obuf_im_q[{1'b0, k_q}] <= top_im_s[63:0];
            obuf_re_q[{1'b1, k_q}] <= bot_re_s[63:0];
            obuf_im_q[{1'b1, k_q}] <= bot_im_s[63:0];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_Real  = out_re_q;
    assign out_Im    = out_im_q;

endmodule

// File: tb/tb_ifft_butterfly16_stream.sv
// ---------------------------------------------------------------------------
// tb_ifft_butterfly16_stream
//
// Directed self-checking bench for ifft_butterfly16_stream.
//
// The bench sends three frames. Expected results are hand-computed:
//   - reset mid-fill, followed by an impulse frame (x0 = 256);
//   - a k = 4 twiddle frame (x4 = 32768), drained with out_ready 1,0,0,1;
//   - a mixed frame. It includes x0 = -1 (rounding) and two non-trivial pairs.
// It also checks the COMPUTE latency, the in_ready drop and recovery, the
// data hold under stall, and out_last placement.
// ---------------------------------------------------------------------------
module tb_ifft_butterfly16_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_Real;
    logic [63:0] in_Im;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_Real;
    logic [63:0] out_Im;
    logic        out_last;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [63:0] fr_re [16];
    logic [63:0] fr_im [16];
    logic [63:0] exp_re[16];
    logic [63:0] exp_im[16];
    logic [63:0] got_re[16];
    logic [63:0] got_im[16];

    always #5 clk = ~clk;

    ifft_butterfly16_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_Real   (in_Real),
        .in_Im     (in_Im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Real  (out_Real),
        .out_Im    (out_Im),
        .out_last  (out_last)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        check_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     tag, $signed(obs), obs, $signed(exp_v), exp_v);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            fr_re[i]  = 64'd0;
            fr_im[i]  = 64'd0;
            exp_re[i] = 64'd0;
            exp_im[i] = 64'd0;
        end
    endtask

    // Push fr_* in order. On return we are at the negedge of cycle T+1.
    task automatic send_frame();
        for (int i = 0; i < 16; i++) begin
            int budget;
            budget = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_Real  = fr_re[i];
            in_Im    = fr_im[i];
            while (!in_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                check_val("accept_timeout", 64'(in_ready), 64'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_Real  = 64'd0;
        in_Im    = 64'd0;
    endtask

    // Check the input-side drop and the COMPUTE latency. With junk = 1, the
    // bench drives in_valid during COMPUTE, and the block must ignore it.
    task automatic wait_output(input bit junk);
        int n;
        check_val("in_ready_drop", 64'(in_ready), 64'd0);
        check_val("compute_out_re_zero", out_Real, 64'd0);
        if (junk) begin
            in_valid = 1'b1;
            in_Real  = 64'h0000_0000_0000_DEAD;
            in_Im    = 64'h0000_0000_0000_BEEF;
        end
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_Real  = 64'd0;
        in_Im    = 64'd0;
        check_val("latency", 64'(n), 64'd9);
    endtask

    // Drain one frame into got_*. With bp = 1, out_ready follows 1,0,0,1.
    task automatic receive_frame(input bit bp, output int cycles);
        int          idx;
        int          cyc;
        bit          prev_stall;
        logic [63:0] prev_re;
        logic [63:0] prev_im;
        logic        prev_last;
        logic [3:0]  pat;
        pat        = 4'b1001;
        idx        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_re    = 64'd0;
        prev_im    = 64'd0;
        prev_last  = 1'b0;
        while (idx < 16 && cyc < 200) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                check_val("hold_re", out_Real, prev_re);
                check_val("hold_im", out_Im, prev_im);
                check_val("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                got_re[idx] = out_Real;
                got_im[idx] = out_Im;
                check_val($sformatf("out_last_at_%0d", idx), 64'(out_last), 64'(idx == 15));
                idx++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid;
                prev_re    = out_Real;
                prev_im    = out_Im;
                prev_last  = out_last;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        cycles    = cyc;
        check_val("handshakes", 64'(idx), 64'd16);
        check_val("in_ready_back", 64'(in_ready), 64'd1);
        check_val("out_valid_done", 64'(out_valid), 64'd0);
        check_val("out_re_after_drain", out_Real, 64'd0);
    endtask

    task automatic compare_frame(input string name);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("%s_y%0d_re", name, i), got_re[i], exp_re[i]);
            check_val($sformatf("%s_y%0d_im", name, i), got_im[i], exp_im[i]);
        end
    endtask

    // Guard against a hung design.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_Real   = 64'd0;
        in_Im     = 64'd0;
        out_ready = 1'b0;

        // Reset state after the first edge.
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_last", 64'(out_last), 64'd0);
        check_val("rst_out_re", out_Real, 64'd0);
        check_val("rst_out_im", out_Im, 64'd0);
        rst = 1'b0;

        // Partial frame of junk, then reset mid-FILL for 3 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_Real  = 64'd999;
            in_Im    = 64'd777;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("midrst_in_ready", 64'(in_ready), 64'd1);
            check_val("midrst_out_valid", 64'(out_valid), 64'd0);
            check_val("midrst_out_re", out_Real, 64'd0);
            check_val("midrst_out_im", out_Im, 64'd0);
        end
        rst = 1'b0;

        // Impulse: y0 = 1, y8 = (256*128)>>>15 = 1.
        clear_frame();
        fr_re[0]  = 64'd256;
        exp_re[0] = 64'd1;
        exp_re[8] = 64'd1;
        send_frame();
        wait_output(1'b0);
        receive_frame(1'b0, cycles);
        check_val("drain_cycles", 64'(cycles), 64'd16);
        compare_frame("imp");

        // k = 4: y4 = 32768>>>8 = 128, y12 = j*(32768*128)>>>15 = 0 + 128j.
        clear_frame();
        fr_re[4]   = 64'd32768;
        exp_re[4]  = 64'd128;
        exp_im[12] = 64'd128;
        send_frame();
        wait_output(1'b1);
        receive_frame(1'b1, cycles);
        compare_frame("k4");

        // Mixed frame.
        //   x0 = -1                         -> y0  = -1>>>8, y8 = -128>>>15
        //   x1 = 1000+500j, x9 = -200+300j  -> sum 800+800j, diff 1200+200j
        //       diff*C1: re 131800, im 82400
        //   x2 = -1000                      -> y2 = -1000>>>8, y10 = (-90000,-90000)>>>15
        clear_frame();
        fr_re[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        fr_re[1] = 64'd1000;
        fr_im[1] = 64'd500;
        fr_re[9] = -64'sd200;
        fr_im[9] = 64'd300;
        fr_re[2] = -64'sd1000;
`ifdef IFFT_ROUND_EN
        exp_re[0]  = 64'd0;
        exp_re[8]  = 64'd0;
        exp_im[9]  = 64'd3;
`else
        exp_re[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_re[8]  = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_im[9]  = 64'd2;
`endif
        exp_re[1]  = 64'd3;
        exp_im[1]  = 64'd3;
        exp_re[9]  = 64'd4;
        exp_re[2]  = -64'sd4;
        exp_re[10] = -64'sd3;
        exp_im[10] = -64'sd3;
        send_frame();
        wait_output(1'b0);
        receive_frame(1'b0, cycles);
        check_val("drain_cycles_mixed", 64'(cycles), 64'd16);
        compare_frame("mix");

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
